// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus: widths, FSM states, size codes.
package periph_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } bus_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } bus_size_e;

endpackage

// File: rtl/periph_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_grant wins.
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_MASTERS-1:0] pick,
  output logic [IDX_W-1:0]       pick_idx,
  output logic                   any_valid
);

  int rank;
  int best_rank;

  // Rank each requester by its distance after last_grant; the lowest rank wins.
  always_comb begin
    rank      = 0;
    best_rank = NUM_MASTERS;
    pick_idx  = '0;
    any_valid = 1'b0;
    pick      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rank = i - int'(last_grant) - 1;
      if (rank < 0) rank = rank + NUM_MASTERS;
      if (m_req[i] && (rank < best_rank)) begin
        best_rank = rank;
        pick_idx  = IDX_W'(i);
        any_valid = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      pick[i] = any_valid && (IDX_W'(i) == pick_idx);
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin owner of the shared peripheral bus; sequences one transaction at a time.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS   = 2,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*2-1:0]      m_size,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]             m_rdata,
  inout  wire  [DATA_W-1:0]             data_bi,
  output logic [ADDR_W-1:0]             address,
  output logic [1:0]                    size,
  output logic                          mem_write,
  output logic                          mem_read,
  output logic [NUM_MASTERS-1:0]        grant
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_MASTERS - 1);

  bus_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic                   write_q, write_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [1:0]             size_q, size_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   any_valid;

  logic                   sel_write;
  logic [ADDR_W-1:0]      sel_address;
  logic [1:0]             sel_size;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   in_access;

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .m_req      (m_req),
    .last_grant (last_grant_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .any_valid  (any_valid)
  );

  // Route the picked master's request fields towards the latch registers.
  always_comb begin
    sel_write   = 1'b0;
    sel_address = '0;
    sel_size    = '0;
    sel_wdata   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick[i]) begin
        sel_write   = m_write[i];
        sel_address = m_address[i*ADDR_W +: ADDR_W];
        sel_size    = m_size[i*2 +: 2];
        sel_wdata   = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic for the IDLE -> ACCESS -> DONE bus cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          write_d     = sel_write;
          addr_d      = sel_address;
          size_d      = sel_size;
          wdata_d     = sel_wdata;
          grant_d     = pick;
          grant_idx_d = pick_idx;
          cnt_d       = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (write_q) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = data_bi;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        last_grant_d = grant_idx_q;
        grant_d      = '0;
        state_d      = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops the bus immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      last_grant_q <= LAST_RESET;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign mem_write = in_access & write_q;
  assign mem_read  = in_access & ~write_q;
  assign address   = in_access ? addr_q : '0;
  assign size      = in_access ? size_q : '0;
  assign data_bi   = mem_write ? wdata_q : {DATA_W{1'bz}};
  assign grant     = grant_q;
  assign m_ack     = (state_q == DONE) ? grant_q : '0;
  assign m_rdata   = rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomised and directed bench for periph_bus_arbiter with a transaction-level model.
module tb_periph_bus_arbiter;

  localparam int N  = 2;
  localparam int AC = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      m_req;
  logic [N-1:0]      m_write;
  logic [N*32-1:0]   m_address;
  logic [N*2-1:0]    m_size;
  logic [N*64-1:0]   m_wdata;
  wire  [N-1:0]      m_ack;
  wire  [63:0]       m_rdata;
  wire  [63:0]       data_bi;
  wire  [31:0]       address;
  wire  [1:0]        size;
  wire               mem_write;
  wire               mem_read;
  wire  [N-1:0]      grant;

  int                compared   = 0;
  int                mismatched = 0;
  int                modelLast;
  logic [63:0]       modelRdata;
  logic [N-1:0]      seen;
  int                r;

  periph_bus_arbiter #(
    .NUM_MASTERS   (N),
    .ACCESS_CYCLES (AC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .m_req     (m_req),
    .m_write   (m_write),
    .m_address (m_address),
    .m_size    (m_size),
    .m_wdata   (m_wdata),
    .m_ack     (m_ack),
    .m_rdata   (m_rdata),
    .data_bi   (data_bi),
    .address   (address),
    .size      (size),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .grant     (grant)
  );

  always #5 clock = ~clock;

  // Peripheral model: a fixed register at 0x80000008, an address-derived pattern elsewhere.
  function automatic logic [63:0] periphValue(input logic [31:0] a);
    if (a == 32'h80000008) return 64'hDEADBEEF00000005;
    return {a ^ 32'hA5A5A5A5, a};
  endfunction

  assign data_bi = mem_read ? periphValue(address) : {64{1'bz}};

  function automatic logic [N-1:0] oneHot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: first requester scanning upward after the last winner.
  function automatic int modelPick(input logic [N-1:0] req, input int last);
    for (int off = 1; off <= N; off++) begin
      if (req[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic req, input logic wr, input logic [31:0] a,
                               input logic [1:0] s, input logic [63:0] wd);
    m_req[i]            = req;
    m_write[i]          = wr;
    m_address[i*32 +: 32] = a;
    m_size[i*2 +: 2]    = s;
    m_wdata[i*64 +: 64] = wd;
  endtask

  task automatic randomizeMaster(input int i);
    applyStimulus(i, m_req[i], 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                  {$urandom, $urandom});
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_grant"}, 64'(grant), 64'(0));
    checkOutput({tag, "_ack"}, 64'(m_ack), 64'(0));
    checkOutput({tag, "_mem_write"}, 64'(mem_write), 64'(0));
    checkOutput({tag, "_mem_read"}, 64'(mem_read), 64'(0));
    checkOutput({tag, "_address"}, 64'(address), 64'(0));
    checkOutput({tag, "_size"}, 64'(size), 64'(0));
    checkOutput({tag, "_data_bi"}, data_bi, {64{1'bz}});
    checkOutput({tag, "_rdata"}, m_rdata, modelRdata);
  endtask

  task automatic idleCycle();
    @(posedge clock);
    @(negedge clock);
    checkIdle("idle");
  endtask

  // Runs one transaction from the negedge of an IDLE cycle to the negedge of its DONE cycle.
  task automatic runTransaction(input bit dropReq, input bit scramble, output logic [N-1:0] seenGrant);
    int w;
    logic wr;
    logic [31:0] a;
    logic [1:0] s;
    logic [63:0] wd;
    int nAccess;
    seenGrant = '0;
    w = modelPick(m_req, modelLast);
    if (w < 0) begin
      $display("[TB] runTransaction called with no requester");
      return;
    end
    wr = m_write[w];
    a  = m_address[w*32 +: 32];
    s  = m_size[w*2 +: 2];
    wd = m_wdata[w*64 +: 64];
    nAccess = wr ? 1 : AC;
    @(posedge clock);
    @(negedge clock);
    seenGrant = grant;
    for (int k = 0; k < nAccess; k++) begin
      checkOutput("acc_grant", 64'(grant), 64'(oneHot(w)));
      checkOutput("acc_address", 64'(address), 64'(a));
      checkOutput("acc_size", 64'(size), 64'(s));
      checkOutput("acc_mem_write", 64'(mem_write), 64'(wr));
      checkOutput("acc_mem_read", 64'(mem_read), 64'(!wr));
      checkOutput("acc_data_bi", data_bi, wr ? wd : periphValue(a));
      checkOutput("acc_ack", 64'(m_ack), 64'(0));
      if (k == 0) begin
        if (scramble) randomizeMaster(w);
        if (dropReq) m_req[w] = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
    end
    if (!wr) modelRdata = periphValue(a);
    checkOutput("done_ack", 64'(m_ack), 64'(oneHot(w)));
    checkOutput("done_grant", 64'(grant), 64'(oneHot(w)));
    checkOutput("done_mem_write", 64'(mem_write), 64'(0));
    checkOutput("done_mem_read", 64'(mem_read), 64'(0));
    checkOutput("done_address", 64'(address), 64'(0));
    checkOutput("done_data_bi", data_bi, {64{1'bz}});
    checkOutput("done_rdata", m_rdata, modelRdata);
    modelLast = w;
  endtask

  // Bus hygiene: the two strobes are never active together.
  always @(negedge clock) begin
    if (reset === 1'b0) checkOutput("strobe_exclusive", 64'(mem_read & mem_write), 64'(0));
  end

  initial begin
    reset      = 1'b1;
    m_req      = '0;
    m_write    = '0;
    m_address  = '0;
    m_size     = '0;
    m_wdata    = '0;
    modelLast  = N - 1;
    modelRdata = '0;
    #3;
    checkIdle("reset");
    @(negedge clock);
    reset = 1'b0;
    checkIdle("post_reset");

    $display("[TB] single write from master 0");
    applyStimulus(0, 1'b1, 1'b1, 32'h80000000, 2'd3, 64'h0000000000000001);
    runTransaction(1'b0, 1'b0, seen);
    checkOutput("write_first_grant", 64'(seen), 64'(2'b01));
    m_req = '0;
    idleCycle();

    $display("[TB] single read from master 1");
    applyStimulus(1, 1'b1, 1'b0, 32'h80000008, 2'd3, 64'h0);
    runTransaction(1'b0, 1'b0, seen);
    checkOutput("read_rdata_const", m_rdata, 64'hDEADBEEF00000005);
    m_req = '0;
    idleCycle();

    $display("[TB] fairness with both masters writing continuously");
    applyStimulus(0, 1'b1, 1'b1, 32'h10000000, 2'd2, 64'h1111);
    applyStimulus(1, 1'b1, 1'b1, 32'h20000000, 2'd2, 64'h2222);
    for (int k = 0; k < 4; k++) begin
      runTransaction(1'b0, 1'b0, seen);
      checkOutput("fair_grant", 64'(seen), 64'(oneHot(k % 2)));
      if (k == 3) m_req = 2'b01;
      idleCycle();
    end

    $display("[TB] master 0 drops its request and changes fields mid-transaction");
    applyStimulus(0, 1'b1, 1'b1, 32'h30000000, 2'd1, 64'hCAFE);
    runTransaction(1'b1, 1'b1, seen);
    checkOutput("drop_req_low", 64'(m_req), 64'(0));
    idleCycle();

    $display("[TB] randomised traffic");
    for (int t = 0; t < 24; t++) begin
      if (m_req == '0) begin
        idleCycle();
        r = $urandom_range(0, N - 1);
        m_req[r] = 1'b1;
        randomizeMaster(r);
      end
      runTransaction($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, seen);
      m_req[modelLast] = 1'($urandom_range(0, 1));
      if (m_req[modelLast]) randomizeMaster(modelLast);
      for (int i = 0; i < N; i++) begin
        if (!m_req[i] && ($urandom_range(0, 2) == 0)) begin
          m_req[i] = 1'b1;
          randomizeMaster(i);
        end
      end
      idleCycle();
    end

    $display("[TB] reset while idle");
    m_req = '0;
    idleCycle();
    #2 reset = 1'b1;
    modelRdata = '0;
    #1;
    checkIdle("reset_idle");
    @(negedge clock);
    reset = 1'b0;
    modelLast = N - 1;

    $display("[TB] reset during a read access");
    applyStimulus(0, 1'b1, 1'b0, 32'h40000000, 2'd3, 64'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h50000000, 2'd3, 64'h0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("abort_read_active", 64'(mem_read), 64'(1));
    #2 reset = 1'b1;
    #1;
    checkIdle("abort_async");
    @(posedge clock);
    @(negedge clock);
    checkOutput("abort_no_ack", 64'(m_ack), 64'(0));
    reset = 1'b0;
    modelLast = N - 1;
    runTransaction(1'b0, 1'b0, seen);
    checkOutput("abort_next_winner", 64'(seen), 64'(2'b01));
    m_req = '0;
    idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the single memory-mapped peripheral bus (Timer and sibling peripherals) between NUM_MASTERS requesters, e.g. the CPU load/store unit and a debug/DMA port.
- Each master issues one transaction at a time with a req/ack handshake; the arbiter grants round-robin and sequences the bus cycle.
- The bus cycle is mem_write/mem_read, address, size, and the bidirectional 64-bit data_bi.
- The arbiter is the only driver of the peripheral-side control signals.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..4).
- ACCESS_CYCLES, 2, clocks mem_read is held before read data is sampled (>=1).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- m_req  input  NUM_MASTERS  per-master request; held until matching m_ack.
- m_write  input  NUM_MASTERS  1 = write, 0 = read; valid while m_req high.
- m_address  input  NUM_MASTERS*32  flattened per-master addresses; master i occupies bits [32i+31:32i].
- m_size  input  NUM_MASTERS*2  flattened access sizes.
- m_wdata  input  NUM_MASTERS*64  flattened write data.
- m_ack  output  NUM_MASTERS  one-cycle completion pulse, one-hot.
- m_rdata  output  64  read data of the last completed read.
- data_bi  inout  64  peripheral data bus.
- address  output  32  peripheral address.
- size  output  2  peripheral access size.
- mem_write  output  1  peripheral write strobe.
- mem_read  output  1  peripheral read strobe.
- grant  output  NUM_MASTERS  one-hot owner of the current transaction; 0 when idle.

Behaviour:
- Interface timing: single clock, clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; data_bi released (Z); FSM in IDLE; last_grant = NUM_MASTERS-1, so master 0 wins first.
- FSM: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any m_req bit is set, pick the first requesting master scanning from last_grant+1 upward, modulo NUM_MASTERS.
  - Latch that master's write, address, size and wdata into internal registers; set grant; cnt = 0; go to ACCESS.
  - If no request, stay in IDLE.
- ACCESS:
  - address and size are driven from the latched values.
  - Write: mem_write = 1 and data_bi is driven with latched wdata for exactly 1 cycle, then go to DONE.
  - Read: mem_read = 1 and data_bi is Z. cnt increments each cycle. On the edge where cnt == ACCESS_CYCLES-1, capture data_bi into m_rdata and go to DONE.
- DONE:
  - m_ack[granted] = 1 for this cycle only; mem_read and mem_write are 0; data_bi is Z.
  - last_grant = granted index; grant clears on exit; go to IDLE.
- Latency, from the edge where a request is sampled in IDLE:
  - write: ack is high during the 2nd cycle after that edge;
  - read: ack is high during the (ACCESS_CYCLES+1)th cycle.
  - One IDLE cycle always separates transactions, so maximum throughput is one write per 3 cycles.
- Output timing:
  - All peripheral-side outputs are registered or derived from state registers only; no combinational path from m_* to the peripheral bus.
  - address and size are 0 outside ACCESS.
- m_rdata holds its value until the next read completes; writes do not alter it.
- Fairness: a master that was just served has the lowest priority on the next arbitration. With all masters requesting continuously, grants rotate 0,1,...,N-1,0.
- Boundary cases:
  - Request-field changes after the IDLE latch edge are ignored.
  - A master that drops m_req mid-transaction still completes and still receives its ack.
  - If m_req is still high in the cycle after ack, it is a new request.
  - Requests arriving during ACCESS or DONE wait; nothing is lost or queued beyond m_req itself.
  - Reset asserted mid-transaction: immediate return to reset values. No ack is issued and the peripheral strobe drops asynchronously.
- Bus contention: data_bi is never driven while mem_read is 1 or outside a write ACCESS cycle.

Decomposition:
- Shared header periph_bus_defs.vh:
  - FSM state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - size codes (byte/half/word/dword = 0..3);
  - peripheral address/data widths (32/64), shared with the Timer and other peripherals.
- One sub-module, rr_arbiter: combinational round-robin pick.
  - Inputs: m_req, last_grant. Outputs: one-hot pick, pick index, any-valid.
  - Instantiated once; the FSM and datapath muxing stay in periph_bus_arbiter.

Test Plan:
- Reset/idle: assert reset mid-run, no requests -> all outputs 0 and data_bi Z within the same time step. After release: grant=0, no strobes.
- Single write: m0 writes 0x0000000000000001 to 0x80000000, size 3 -> one cycle later: mem_write=1, address=0x80000000, data_bi=0x1 for exactly 1 cycle; m_ack[0] pulses the next cycle.
- Single read, ACCESS_CYCLES=2: m1 reads 0x80000008 with a peripheral model returning 0xDEADBEEF00000005 -> mem_read high exactly 2 cycles; m_rdata=0xDEADBEEF00000005 when m_ack[1] pulses.
- Contention and fairness: m0 and m1 request continuously from reset -> grant sequence 0,1,0,1. Each ack is one cycle, never overlapping, 3 cycles apart for writes.
- Abort cases:
  - m0 drops m_req during ACCESS -> transaction completes, m_ack[0] still pulses.
  - Reset during a read's ACCESS -> no ack, mem_read=0 immediately; master 0 wins the next arbitration.
- Bus hygiene: monitor over all scenarios -> data_bi is never non-Z while mem_read=1; mem_read and mem_write are never both 1.
